rd_fram_fill_ctrl: RTL

//  Write-side scheduler for the HDMI read line buffer (256b write / 32b read SDP RAM).
//  Per display line request, issues DDR read bursts and streams the returned 256-bit words

---
 rtl/rd_fram_fill_ctrl_if.sv | 48 ++++
 rtl/rd_fram_fill_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rd_fram_fill_ctrl_if.sv
// ----------------------------------------------------------------------------
// rd_fram_fill_ctrl_if
//   Bundles the line-fill scheduler's control, DDR read-command, DDR read-data
//   and line-buffer write signals.
//   master : the fill controller (issues DDR commands, writes the buffer)
//   slave  : its environment (display sync, DDR read port, line buffer)
// Signals
//   frame_base/frame_start/line_req    frame and line requests into the filler
//   cmd_valid/cmd_ready/cmd_addr/len   DDR read command (len = words - 1)
//   rdat_valid/rdat                    DDR read data beats, no back-pressure
//   buf_wr_en/buf_wr_addr/buf_wr_data  line buffer write port, addr = {bank, word}
//   line_done/line_bank                completion pulse and the bank just filled
//   busy/err                           fill in progress / sticky error
// ----------------------------------------------------------------------------
interface rd_fram_fill_ctrl_if #(
    parameter int DATA_WIDTH    = 256,
    parameter int WR_ADDR_WIDTH = 9,
    parameter int ADDR_WIDTH    = 28
);
    logic [ADDR_WIDTH-1:0]    frame_base;
    logic                     frame_start;
    logic                     line_req;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [ADDR_WIDTH-1:0]    cmd_addr;
    logic [7:0]               cmd_len;
    logic                     rdat_valid;
    logic [DATA_WIDTH-1:0]    rdat;
    logic                     buf_wr_en;
    logic [WR_ADDR_WIDTH-1:0] buf_wr_addr;
    logic [DATA_WIDTH-1:0]    buf_wr_data;
    logic                     line_done;
    logic                     line_bank;
    logic                     busy;
    logic                     err;

    modport master (
        input  frame_base, frame_start, line_req, cmd_ready, rdat_valid, rdat,
        output cmd_valid, cmd_addr, cmd_len, buf_wr_en, buf_wr_addr, buf_wr_data,
               line_done, line_bank, busy, err
    );

    modport slave (
        output frame_base, frame_start, line_req, cmd_ready, rdat_valid, rdat,
        input  cmd_valid, cmd_addr, cmd_len, buf_wr_en, buf_wr_addr, buf_wr_data,
               line_done, line_bank, busy, err
    );
endinterface

// File: rtl/rd_fram_fill_ctrl.sv
// ----------------------------------------------------------------------------
// rd_fram_fill_ctrl
//   Write-side scheduler for the HDMI ping-pong line buffer. Each line request
//   fetches one display line from DDR as a series of read bursts and streams
//   the returned words into the bank the display is not reading.
// Ports
//   wr_clk   DDR/write-domain clock
//   wr_rst   asynchronous, active-high reset
//   bus      rd_fram_fill_ctrl_if.master (requests, DDR command/data, buffer
//            write port, line_done/line_bank, busy, err)
// ----------------------------------------------------------------------------
module rd_fram_fill_ctrl #(
    parameter int DATA_WIDTH      = 256,
    parameter int WR_ADDR_WIDTH   = 9,
    parameter int ADDR_WIDTH      = 28,
    parameter int LINE_WORDS      = 240,
    parameter int BURST_LEN       = 16,
    parameter int LINE_STRIDE     = 7680,
    parameter int LINES_PER_FRAME = 1080
) (
    input  logic                wr_clk,
    input  logic                wr_rst,
    rd_fram_fill_ctrl_if.master bus
);

    localparam int WIDX_W         = WR_ADDR_WIDTH - 1;
    localparam int WCNT_W         = $clog2(LINE_WORDS + 1);
    localparam int LIDX_W         = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
    localparam int BEAT_W         = $clog2(BURST_LEN + 1);
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_DONE} state_e;

    state_e                   state_q, state_d;
    logic [LIDX_W-1:0]        line_idx_q, line_idx_d;
    logic                     bank_q, bank_d;
    logic                     pending_q, pending_d;
    logic                     restart_q, restart_d;      // frame_start seen while busy
    logic [ADDR_WIDTH-1:0]    base_q, base_d;
    logic [ADDR_WIDTH-1:0]    line_addr_q, line_addr_d;  // byte address of current line
    logic [WCNT_W-1:0]        words_issued_q, words_issued_d;
    logic [WIDX_W-1:0]        word_idx_q, word_idx_d;
    logic [BEAT_W-1:0]        beats_left_q, beats_left_d;
    logic                     err_q, err_d;
    logic                     buf_wr_en_q, buf_wr_en_d;
    logic [WR_ADDR_WIDTH-1:0] buf_wr_addr_q, buf_wr_addr_d;
    logic [DATA_WIDTH-1:0]    buf_wr_data_q, buf_wr_data_d;
    logic                     line_done_q, line_done_d;
    logic                     line_bank_q, line_bank_d;

    logic [31:0]              words_left;
    logic [31:0]              burst_words;
    logic                     start_line;
    logic                     last_beat;
    logic                     line_complete;
    logic                     restart_now;

    // ------------------------------------------------------------------
    // Burst sizing: full bursts until the tail of the line, then a short one.
    // ------------------------------------------------------------------
    always_comb begin : burst_size
        // NOTE: combinational blocks assign every output up front, so no path
        // can leave a value unassigned and infer a latch.
        words_left  = 32'(LINE_WORDS) - 32'(words_issued_q);
        burst_words = (words_left > 32'(BURST_LEN)) ? 32'(BURST_LEN) : words_left;
    end

    assign start_line    = (state_q == ST_IDLE) && pending_q && !bus.frame_start;
    assign last_beat     = bus.rdat_valid && (beats_left_q == BEAT_W'(1));
    // words_issued already counts the burst in flight, so this means "no more bursts".
    assign line_complete = (words_issued_q == WCNT_W'(LINE_WORDS));
    assign restart_now   = restart_q || bus.frame_start;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge wr_clk or posedge wr_rst) begin : state_reg
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (wr_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_line)     state_d = ST_CMD;
            ST_CMD:  if (bus.cmd_ready)  state_d = ST_DATA;
            ST_DATA: if (last_beat)      state_d = line_complete ? ST_DONE : ST_CMD;
            ST_DONE:                     state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (command address/length forced to 0 while not requesting)
    // ------------------------------------------------------------------
    always_comb begin : fsm_outputs
        bus.cmd_valid = (state_q == ST_CMD);
        bus.busy      = (state_q != ST_IDLE);
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        if (state_q == ST_CMD) begin
            bus.cmd_addr = line_addr_q
                         + ADDR_WIDTH'(words_issued_q) * ADDR_WIDTH'(BYTES_PER_WORD);
            bus.cmd_len  = 8'(burst_words - 32'd1);
        end
    end

    assign bus.buf_wr_en   = buf_wr_en_q;
    assign bus.buf_wr_addr = buf_wr_addr_q;
    assign bus.buf_wr_data = buf_wr_data_q;
    assign bus.line_done   = line_done_q;
    assign bus.line_bank   = line_bank_q;
    assign bus.err         = err_q;

    // ------------------------------------------------------------------
    // Datapath / bookkeeping next-state
    // ------------------------------------------------------------------
    always_comb begin : datapath_next
        line_idx_d     = line_idx_q;
        bank_d         = bank_q;
        pending_d      = pending_q;
        restart_d      = restart_q;
        base_d         = base_q;
        line_addr_d    = line_addr_q;
        words_issued_d = words_issued_q;
        word_idx_d     = word_idx_q;
        beats_left_d   = beats_left_q;
        err_d          = err_q;
        buf_wr_en_d    = 1'b0;
        buf_wr_addr_d  = buf_wr_addr_q;
        buf_wr_data_d  = buf_wr_data_q;
        line_done_d    = 1'b0;
        line_bank_d    = line_bank_q;

        if (start_line) begin
            pending_d      = 1'b0;
            words_issued_d = '0;
            word_idx_d     = '0;
        end

        if (state_q == ST_CMD && bus.cmd_ready) begin
            words_issued_d = words_issued_q + WCNT_W'(burst_words);
            beats_left_d   = BEAT_W'(burst_words);
        end

        if (bus.rdat_valid) begin
            if (state_q == ST_DATA) begin
                buf_wr_en_d   = 1'b1;
                buf_wr_addr_d = {bank_q, word_idx_q};
                buf_wr_data_d = bus.rdat;
                word_idx_d    = word_idx_q + WIDX_W'(1);
                beats_left_d  = beats_left_q - BEAT_W'(1);
            end else begin
                err_d = 1'b1;  // unsolicited beat: dropped
            end
        end

        // Request handling; frame_start swallows a coincident line_req.
        if (bus.frame_start) begin
            base_d = bus.frame_base;
            if (state_q == ST_IDLE) begin
                line_idx_d  = '0;
                bank_d      = 1'b0;
                line_addr_d = bus.frame_base;
                pending_d   = 1'b1;
            end else begin
                restart_d   = 1'b1;
            end
        end else if (bus.line_req) begin
            if (pending_q && !start_line) err_d = 1'b1;
            else                          pending_d = 1'b1;
        end

        // Line retire: report the bank, then move to the next line or restart.
        if (state_q == ST_DONE) begin
            line_done_d = 1'b1;
            line_bank_d = bank_q;
            if (restart_now) begin
                restart_d   = 1'b0;
                line_idx_d  = '0;
                bank_d      = 1'b0;
                line_addr_d = bus.frame_start ? bus.frame_base : base_q;
                pending_d   = 1'b1;  // any queued line_req is superseded
            end else begin
                bank_d = ~bank_q;
                if (line_idx_q == LIDX_W'(LINES_PER_FRAME - 1)) begin
                    line_idx_d  = '0;
                    line_addr_d = base_q;
                end else begin
                    line_idx_d  = line_idx_q + LIDX_W'(1);
                    line_addr_d = line_addr_q + ADDR_WIDTH'(LINE_STRIDE);
                end
            end
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin : datapath_reg
        if (wr_rst) begin
            line_idx_q     <= '0;
            bank_q         <= 1'b0;
            pending_q      <= 1'b0;
            restart_q      <= 1'b0;
            base_q         <= '0;
            line_addr_q    <= '0;
            words_issued_q <= '0;
            word_idx_q     <= '0;
            beats_left_q   <= '0;
            err_q          <= 1'b0;
            buf_wr_en_q    <= 1'b0;
            buf_wr_addr_q  <= '0;
            buf_wr_data_q  <= '0;
            line_done_q    <= 1'b0;
            line_bank_q    <= 1'b0;
        end else begin
            line_idx_q     <= line_idx_d;
            bank_q         <= bank_d;
            pending_q      <= pending_d;
            restart_q      <= restart_d;
            base_q         <= base_d;
            line_addr_q    <= line_addr_d;
            words_issued_q <= words_issued_d;
            word_idx_q     <= word_idx_d;
            beats_left_q   <= beats_left_d;
            err_q          <= err_d;
            buf_wr_en_q    <= buf_wr_en_d;
            buf_wr_addr_q  <= buf_wr_addr_d;
            buf_wr_data_q  <= buf_wr_data_d;
            line_done_q    <= line_done_d;
            line_bank_q    <= line_bank_d;
        end
    end

endmodule
